// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response bundle between the fetch
// stage and the instruction memory.
//   imem_req    fetch -> mem  request valid (at most one outstanding)
//   imem_addr   fetch -> mem  10-bit fetch address
//   imem_gnt    mem -> fetch  request accepted this cycle
//   imem_rvalid mem -> fetch  read data valid, one per granted request, in order
//   imem_rdata  mem -> fetch  12-bit instruction word
interface fetch_if;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [11:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch.sv
// fetch: single-outstanding-request instruction fetch stage.
// Issues one request per instruction from IDLE, waits for the in-order
// response, and presents the instruction plus (fetch address + 1) in output
// registers. Handles downstream stalls through a one-entry hold register and
// execute redirects by squashing the in-flight response.
// Ports:
//   clk                 clock, rising edge
//   rst                 asynchronous active-high reset
//   imem                fetch_if master (request/grant/response)
//   ex_stall            downstream hold; FE output registers keep their value
//   take_branch         redirect for the instruction now in the FE output
//   next_pc             redirect target
//   instruction_FE_out  registered instruction to execute
//   pc_plus_1_FE_out    registered fetch address + 1 of that instruction
module fetch #(
    parameter logic [9:0]  RESET_PC  = 10'h000,
    parameter logic [11:0] NOP_INSTR = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     imem,
    input  logic        ex_stall,
    input  logic        take_branch,
    input  logic [9:0]  next_pc,
    output logic [11:0] instruction_FE_out,
    output logic [9:0]  pc_plus_1_FE_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } state_t;

    state_t      state;
    logic [9:0]  pc;
    logic [9:0]  pc_inc;
    logic [11:0] hold_instr;
    logic        redirect;

    // A redirect is only honoured while execute is not stalled.
    assign redirect = take_branch & ~ex_stall;
    assign pc_inc   = pc + 10'd1;   // wraps modulo 1024

    // Request is decoded from state so the first request appears in the
    // very first cycle after reset release; rst masks it during reset.
    assign imem.imem_req  = (state == IDLE) && !rst;
    assign imem.imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            pc                 <= RESET_PC;
            hold_instr         <= '0;
            instruction_FE_out <= NOP_INSTR;
            pc_plus_1_FE_out   <= RESET_PC;
        end else begin
            // FE output registers: frozen under stall, otherwise load a new
            // instruction or a bubble (bubble keeps the old pc_plus_1).
            if (!ex_stall) begin
                if (redirect) begin
                    instruction_FE_out <= NOP_INSTR;
                end else if (state == WAIT && imem.imem_rvalid) begin
                    instruction_FE_out <= imem.imem_rdata;
                    pc_plus_1_FE_out   <= pc_inc;
                end else if (state == HOLD) begin
                    // PC was already advanced when the word was captured,
                    // so it equals the held instruction's address + 1.
                    instruction_FE_out <= hold_instr;
                    pc_plus_1_FE_out   <= pc;
                end else begin
                    instruction_FE_out <= NOP_INSTR;
                end
            end

            case (state)
                IDLE: begin
                    if (redirect) begin
                        pc <= next_pc;
                    end
                    // A granted request to the old PC must have its response
                    // dropped when a redirect arrives in the same cycle.
                    if (imem.imem_gnt) begin
                        state <= redirect ? SQUASH : WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc    <= next_pc;
                        state <= imem.imem_rvalid ? IDLE : SQUASH;
                    end else if (imem.imem_rvalid) begin
                        pc <= pc_inc;
                        if (ex_stall) begin
                            hold_instr <= imem.imem_rdata;
                            state      <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= next_pc;
                        state <= IDLE;
                    end else if (!ex_stall) begin
                        state <= IDLE;
                    end
                end
                SQUASH: begin
                    if (redirect) begin
                        pc <= next_pc;
                    end
                    if (imem.imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

    localparam logic [9:0]  RST_PC = 10'h000;
    localparam logic [11:0] N      = 12'h0E0;   // bubble value used in this bench

    logic        clk;
    logic        rst;
    logic        ex_stall;
    logic        take_branch;
    logic [9:0]  next_pc;
    logic [11:0] instruction_FE_out;
    logic [9:0]  pc_plus_1_FE_out;

    fetch_if imem ();

    fetch #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (N)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .imem               (imem.master),
        .ex_stall           (ex_stall),
        .take_branch        (take_branch),
        .next_pc            (next_pc),
        .instruction_FE_out (instruction_FE_out),
        .pc_plus_1_FE_out   (pc_plus_1_FE_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [11:0] rdata;
        logic        stall;
        logic        br;
        logic [9:0]  npc;
        logic        exp_req;
        logic [9:0]  exp_addr;
        logic [11:0] exp_instr;
        logic [9:0]  exp_pcp1;
    } vec_t;

    vec_t vecs [37];
    int   n_cmp;
    int   n_bad;

    function automatic vec_t mk(input logic g, input logic r, input logic [11:0] d,
                                input logic s, input logic b, input logic [9:0] np,
                                input logic er, input logic [9:0] ea,
                                input logic [11:0] ei, input logic [9:0] ep);
        vec_t v;
        v.gnt = g; v.rv = r; v.rdata = d; v.stall = s; v.br = b; v.npc = np;
        v.exp_req = er; v.exp_addr = ea; v.exp_instr = ei; v.exp_pcp1 = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic er, input logic [9:0] ea,
                                 input logic [11:0] ei, input logic [9:0] ep);
        check({tag, ".req"},   {11'd0, imem.imem_req},   {11'd0, er});
        check({tag, ".addr"},  {2'd0, imem.imem_addr},   {2'd0, ea});
        check({tag, ".instr"}, instruction_FE_out,       ei);
        check({tag, ".pcp1"},  {2'd0, pc_plus_1_FE_out}, {2'd0, ep});
    endtask

    task automatic clear_inputs();
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
        ex_stall = 1'b0; take_branch = 1'b0; next_pc = '0;
    endtask

    // Each vector: inputs applied for one cycle, outputs checked after the edge.
    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            imem.imem_gnt    = vecs[i].gnt;
            imem.imem_rvalid = vecs[i].rv;
            imem.imem_rdata  = vecs[i].rdata;
            ex_stall         = vecs[i].stall;
            take_branch      = vecs[i].br;
            next_pc          = vecs[i].npc;
            @(posedge clk);
            #1;
            check_outputs($sformatf("v%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                          vecs[i].exp_instr, vecs[i].exp_pcp1);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //              gnt rv rdata    st br npc       req addr     instr    pcp1
        // basic fetch
        vecs[0]  = mk(1, 0, 12'h000, 0, 0, 10'h000,  0, 10'h000, N,       10'h000);
        vecs[1]  = mk(0, 1, 12'hA5C, 0, 0, 10'h000,  1, 10'h001, 12'hA5C, 10'h001);
        // response under stall, then release
        vecs[2]  = mk(1, 0, 12'h000, 0, 0, 10'h000,  0, 10'h001, N,       10'h001);
        vecs[3]  = mk(0, 1, 12'h123, 1, 0, 10'h000,  0, 10'h002, N,       10'h001);
        vecs[4]  = mk(1, 0, 12'h000, 1, 0, 10'h000,  0, 10'h002, N,       10'h001);
        vecs[5]  = mk(0, 0, 12'h000, 1, 1, 10'h3AA,  0, 10'h002, N,       10'h001);
        vecs[6]  = mk(0, 0, 12'h000, 0, 0, 10'h000,  1, 10'h002, 12'h123, 10'h002);
        // redirect in WAIT, late response squashed
        vecs[7]  = mk(1, 0, 12'h000, 0, 0, 10'h000,  0, 10'h002, N,       10'h002);
        vecs[8]  = mk(0, 0, 12'h000, 0, 1, 10'h040,  0, 10'h040, N,       10'h002);
        vecs[9]  = mk(0, 1, 12'h777, 0, 0, 10'h000,  1, 10'h040, N,       10'h002);
        vecs[10] = mk(1, 0, 12'h000, 0, 0, 10'h000,  0, 10'h040, N,       10'h002);
        vecs[11] = mk(0, 1, 12'h456, 0, 0, 10'h000,  1, 10'h041, 12'h456, 10'h041);
        // redirect together with the response
        vecs[12] = mk(1, 0, 12'h000, 0, 0, 10'h000,  0, 10'h041, N,       10'h041);
        vecs[13] = mk(0, 1, 12'h999, 0, 1, 10'h3FF,  1, 10'h3FF, N,       10'h041);
        // PC wrap
        vecs[14] = mk(1, 0, 12'h000, 0, 0, 10'h000,  0, 10'h3FF, N,       10'h041);
        vecs[15] = mk(0, 1, 12'hABC, 0, 0, 10'h000,  1, 10'h000, 12'hABC, 10'h000);
        // grant withheld five cycles
        vecs[16] = mk(0, 0, 12'h000, 0, 0, 10'h000,  1, 10'h000, N,       10'h000);
        vecs[17] = mk(0, 0, 12'h000, 0, 0, 10'h000,  1, 10'h000, N,       10'h000);
        vecs[18] = mk(0, 0, 12'h000, 0, 0, 10'h000,  1, 10'h000, N,       10'h000);
        vecs[19] = mk(0, 0, 12'h000, 0, 0, 10'h000,  1, 10'h000, N,       10'h000);
        vecs[20] = mk(0, 0, 12'h000, 0, 0, 10'h000,  1, 10'h000, N,       10'h000);
        // redirect in IDLE with grant, second redirect in SQUASH
        vecs[21] = mk(1, 0, 12'h000, 0, 1, 10'h100,  0, 10'h100, N,       10'h000);
        vecs[22] = mk(0, 0, 12'h000, 0, 1, 10'h200,  0, 10'h200, N,       10'h000);
        vecs[23] = mk(0, 1, 12'h555, 0, 0, 10'h000,  1, 10'h200, N,       10'h000);
        // redirect in IDLE without grant
        vecs[24] = mk(0, 0, 12'h000, 0, 1, 10'h080,  1, 10'h080, N,       10'h000);
        // redirect in HOLD
        vecs[25] = mk(1, 0, 12'h000, 0, 0, 10'h000,  0, 10'h080, N,       10'h000);
        vecs[26] = mk(0, 1, 12'h321, 1, 0, 10'h000,  0, 10'h081, N,       10'h000);
        vecs[27] = mk(0, 0, 12'h000, 0, 1, 10'h010,  1, 10'h010, N,       10'h000);
        // stray rvalid in IDLE
        vecs[28] = mk(0, 1, 12'hFFF, 0, 0, 10'h000,  1, 10'h010, N,       10'h000);
        // stall holds a real instruction, then bubble
        vecs[29] = mk(1, 0, 12'h000, 0, 0, 10'h000,  0, 10'h010, N,       10'h000);
        vecs[30] = mk(0, 1, 12'h2B4, 0, 0, 10'h000,  1, 10'h011, 12'h2B4, 10'h011);
        vecs[31] = mk(0, 0, 12'h000, 1, 0, 10'h000,  1, 10'h011, 12'h2B4, 10'h011);
        vecs[32] = mk(0, 0, 12'h000, 0, 0, 10'h000,  1, 10'h011, N,       10'h011);
        vecs[33] = mk(1, 0, 12'h000, 0, 0, 10'h000,  0, 10'h011, N,       10'h011);
        // after reset in WAIT: late response ignored, then a clean fetch
        vecs[34] = mk(0, 1, 12'h6E6, 0, 0, 10'h000,  1, 10'h000, N,       10'h000);
        vecs[35] = mk(1, 0, 12'h000, 0, 0, 10'h000,  0, 10'h000, N,       10'h000);
        vecs[36] = mk(0, 1, 12'h0C3, 0, 0, 10'h000,  1, 10'h001, 12'h0C3, 10'h001);

        clear_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_outputs("reset", 1'b0, RST_PC, N, RST_PC);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs("first_req", 1'b1, RST_PC, N, RST_PC);

        run_vectors(0, 33);

        // Asynchronous reset while a request is outstanding (state WAIT).
        @(negedge clk);
        clear_inputs();
        #2 rst = 1'b1;
        #1;
        check_outputs("async_rst", 1'b0, RST_PC, N, RST_PC);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs("rst_release", 1'b1, RST_PC, N, RST_PC);

        run_vectors(34, 36);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish before 20000");
        $fatal(1);
    end

endmodule
